// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Brief    : Request/response bundle between two ALU requesters, the shared
//            ALU arbiter and the result consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_src1;
    logic [DATA_W-1:0] req0_imm;
    logic [CTRL_W-1:0] req0_ctrl;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_src1;
    logic [DATA_W-1:0] req1_imm;
    logic [CTRL_W-1:0] req1_ctrl;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req0_valid, req0_src1, req0_imm, req0_ctrl,
        output req1_valid, req1_src1, req1_imm, req1_ctrl,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req0_valid, req0_src1, req0_imm, req0_ctrl,
        input  req1_valid, req1_src1, req1_imm, req1_ctrl,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : One ALU (add / pass-imm / add&~1 / unsigned-lt) shared by two
//            requesters with round-robin or fixed-priority arbitration, a
//            single registered result slot and per-port grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 3,
    parameter int CNT_W      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_share_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]      grant_cnt0,
    output logic [CNT_W-1:0]      grant_cnt1
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t       r_state;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_id;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_slot_free;
    logic              w_any;
    logic              w_gnt;
    logic              w_acc;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_imm;
    logic [CTRL_W-1:0] w_ctrl;
    logic [DATA_W-1:0] w_alu;

    function automatic logic [DATA_W-1:0] alu_op(
        input logic [DATA_W-1:0] src1,
        input logic [DATA_W-1:0] imm,
        input logic [CTRL_W-1:0] ctrl
    );
        logic [DATA_W-1:0] sum;
        sum = src1 + imm;
        case (ctrl)
            CTRL_W'(3'd0): alu_op = sum;
            CTRL_W'(3'd1): alu_op = imm;
            CTRL_W'(3'd2): alu_op = sum;
            CTRL_W'(3'd3): alu_op = sum & ~DATA_W'(1);
            CTRL_W'(3'd4): alu_op = {{(DATA_W-1){1'b0}}, (src1 < imm)};
            default:       alu_op = '0;
        endcase
    endfunction

    // Priority only rotates on an actual accept, so idle cycles never shift it.
    always_comb begin
        w_slot_free = (r_state == EMPTY) || bus.resp_ready;
        w_any       = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
        end else begin
            w_gnt = ~bus.req0_valid;
        end
        // The granted port is always a valid one, so ready here is also accept.
        w_acc  = !rst && w_slot_free && w_any;
        w_src1 = w_gnt ? bus.req1_src1 : bus.req0_src1;
        w_imm  = w_gnt ? bus.req1_imm  : bus.req0_imm;
        w_ctrl = w_gnt ? bus.req1_ctrl : bus.req0_ctrl;
        w_alu  = alu_op(w_src1, w_imm, w_ctrl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_resp_data  <= '0;
            r_resp_id    <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else if (w_acc) begin
            r_state      <= FULL;
            r_resp_data  <= w_alu;
            r_resp_id    <= w_gnt;
            r_last_grant <= w_gnt;
            if (w_gnt) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end else begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
        end else if (bus.resp_ready) begin
            r_state <= EMPTY;
        end
    end

    assign bus.req0_ready = w_acc && !w_gnt;
    assign bus.req1_ready = w_acc &&  w_gnt;
    assign bus.resp_valid = (r_state == FULL);
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_data  = r_resp_data;
    assign grant_cnt0     = r_cnt0;
    assign grant_cnt1     = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Drives a round-robin (CNT_W=4) and a fixed-priority (CNT_W=16)
//            arbiter with identical stimulus and compares both to a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic        v0, v1, rr;
    logic [31:0] s0, i0, s1, i1;
    logic [2:0]  c0, c1;

    int n_checks = 0;
    int n_errors = 0;

    alu_share_arbiter_if #(.DATA_W(32), .CTRL_W(3)) bus_a ();
    alu_share_arbiter_if #(.DATA_W(32), .CTRL_W(3)) bus_b ();

    logic [3:0]  cnt_a0, cnt_a1;
    logic [15:0] cnt_b0, cnt_b1;

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(3), .CNT_W(4), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .grant_cnt0(cnt_a0), .grant_cnt1(cnt_a1)
    );
    alu_share_arbiter #(.DATA_W(32), .CTRL_W(3), .CNT_W(16), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .grant_cnt0(cnt_b0), .grant_cnt1(cnt_b1)
    );

    assign bus_a.req0_valid = v0;  assign bus_b.req0_valid = v0;
    assign bus_a.req0_src1  = s0;  assign bus_b.req0_src1  = s0;
    assign bus_a.req0_imm   = i0;  assign bus_b.req0_imm   = i0;
    assign bus_a.req0_ctrl  = c0;  assign bus_b.req0_ctrl  = c0;
    assign bus_a.req1_valid = v1;  assign bus_b.req1_valid = v1;
    assign bus_a.req1_src1  = s1;  assign bus_b.req1_src1  = s1;
    assign bus_a.req1_imm   = i1;  assign bus_b.req1_imm   = i1;
    assign bus_a.req1_ctrl  = c1;  assign bus_b.req1_ctrl  = c1;
    assign bus_a.resp_ready = rr;  assign bus_b.resp_ready = rr;

    // Index 0 = round-robin DUT, index 1 = fixed-priority DUT
    logic        o_v[2], o_id[2], o_r0[2], o_r1[2];
    logic [31:0] o_d[2];
    logic [15:0] o_c0[2], o_c1[2];
    assign o_v[0]  = bus_a.resp_valid;  assign o_v[1]  = bus_b.resp_valid;
    assign o_id[0] = bus_a.resp_id;     assign o_id[1] = bus_b.resp_id;
    assign o_d[0]  = bus_a.resp_data;   assign o_d[1]  = bus_b.resp_data;
    assign o_r0[0] = bus_a.req0_ready;  assign o_r0[1] = bus_b.req0_ready;
    assign o_r1[0] = bus_a.req1_ready;  assign o_r1[1] = bus_b.req1_ready;
    assign o_c0[0] = {12'd0, cnt_a0};   assign o_c0[1] = cnt_b0;
    assign o_c1[0] = {12'd0, cnt_a1};   assign o_c1[1] = cnt_b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit          m_v[2], m_id[2], m_last[2], m_rst[2];
    logic [31:0] m_d[2];
    int          m_c0[2], m_c1[2];
    int          m_mod[2] = '{16, 65536};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0, 3'd2: return a + b;
            3'd1:       return b;
            3'd3:       return (a + b) & 32'hFFFF_FFFE;
            3'd4:       return (a < b) ? 32'd1 : 32'd0;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_v[d] = 0; m_id[d] = 0; m_d[d] = '0; m_last[d] = 1;
            m_c0[d] = 0; m_c1[d] = 0; m_rst[d] = 1;
        end
    endtask

    // Entered at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        bit free, win, e0, e1;
        #1;
        for (int d = 0; d < 2; d++) begin
            free = !m_v[d] || rr;
            if (v0 && v1) win = (d == 1) ? 1'b0 : !m_last[d];
            else          win = !v0;
            e0 = !rst && free && v0 && !win;
            e1 = !rst && free && v1 &&  win;
            check_val($sformatf("dut%0d.req0_ready", d), 64'(o_r0[d]), 64'(e0));
            check_val($sformatf("dut%0d.req1_ready", d), 64'(o_r1[d]), 64'(e1));
            m_rst[d] = 0;
            if (rst) begin
                m_v[d] = 0; m_id[d] = 0; m_d[d] = '0; m_last[d] = 1;
                m_c0[d] = 0; m_c1[d] = 0; m_rst[d] = 1;
            end else if (e0 || e1) begin
                m_v[d]    = 1;
                m_id[d]   = e1;
                m_last[d] = e1;
                m_d[d]    = e1 ? ref_alu(s1, i1, c1) : ref_alu(s0, i0, c0);
                if (e1) m_c1[d] = (m_c1[d] + 1) % m_mod[d];
                else    m_c0[d] = (m_c0[d] + 1) % m_mod[d];
            end else if (rr) begin
                m_v[d] = 0;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("dut%0d.resp_valid", d), 64'(o_v[d]), 64'(m_v[d]));
            if (m_v[d] || m_rst[d]) begin
                check_val($sformatf("dut%0d.resp_id", d),   64'(o_id[d]), 64'(m_id[d]));
                check_val($sformatf("dut%0d.resp_data", d), 64'(o_d[d]),  64'(m_d[d]));
            end
            check_val($sformatf("dut%0d.grant_cnt0", d), 64'(o_c0[d]), 64'(m_c0[d]));
            check_val($sformatf("dut%0d.grant_cnt1", d), 64'(o_c1[d]), 64'(m_c1[d]));
        end
    endtask

    task automatic do_reset();
        rst = 1; v0 = 0; v1 = 0; rr = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1; v0 = 0; v1 = 0; rr = 1;
        s0 = '0; i0 = '0; s1 = '0; i1 = '0; c0 = '0; c1 = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Port 0 alone: next-PC style add
        v0 = 1; s0 = 32'h8000_0000; i0 = 32'd4; c0 = 3'b000;
        cycle();
        check_val("t1.resp_data", 64'(o_d[0]), 64'h8000_0004);
        check_val("t1.resp_id", 64'(o_id[0]), 64'd0);
        check_val("t1.grant_cnt0", 64'(o_c0[0]), 64'd1);

        // Both valid every cycle: RR alternates, fixed-priority stays on port 0
        do_reset();
        v0 = 1; v1 = 1; s0 = 32'h10; i0 = 32'h20; c0 = 3'b000;
        s1 = 32'h1000; i1 = 32'h7; c1 = 3'b011;
        cycle();
        cycle();
        check_val("t2.rr_id", 64'(o_id[0]), 64'd1);
        check_val("t2.rr_and", 64'(o_d[0]), 64'h1006);
        s1 = 32'd3; i1 = 32'hFFFF_FFFF; c1 = 3'b100;
        cycle();
        cycle();
        check_val("t2.rr_lt", 64'(o_d[0]), 64'd1);
        check_val("t4.fp_cnt0", 64'(o_c0[1]), 64'd4);
        check_val("t4.fp_cnt1", 64'(o_c1[1]), 64'd0);

        // Backpressure: three stalled cycles, then release with requests pending
        rr = 0;
        repeat (3) cycle();
        rr = 1;
        cycle();
        cycle();

        // Counter wrap on the 4-bit counters, plus an undefined op code
        do_reset();
        v1 = 0; v0 = 1; c0 = 3'b111; s0 = 32'h1234; i0 = 32'h5678;
        repeat (17) cycle();
        check_val("t5.cnt_wrap", 64'(o_c0[0]), 64'd1);
        check_val("t5.op111", 64'(o_d[0]), 64'd0);

        // Reset while the slot is full and both ports request
        v0 = 1; v1 = 1; rr = 0; c0 = 3'b001;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        check_val("t6.first_conflict", 64'(o_id[0]), 64'd0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(63) == 0);
            v0  = ($urandom_range(3) != 0);
            v1  = ($urandom_range(3) != 0);
            rr  = ($urandom_range(3) != 0);
            s0  = rnd_op(); i0 = rnd_op(); c0 = 3'($urandom_range(7));
            s1  = rnd_op(); i1 = rnd_op(); c1 = 3'($urandom_range(7));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
